fft_bf_sched: RTL and testbench
===============================

Name: fft_bf_sched

Overview:
- Sequences an in-place radix-2 DIT FFT over the 32 x n dual-read/dual-write register file (%0 hard-wired to zero).
- Issues one butterfly per cycle: two read addresses, a twiddle index and an operand-valid strobe to the butterfly datapath.
- Delays the pair addresses by the butterfly latency and drives both write ports when the results emerge.
- Sits between the top-level control (start/done) and the register file plus butterfly pipeline.

Parameters:
- LOG2N, 4, log2 of FFT points; N = 2**LOG2N.
- BASE, 16, register index of sample 0; samples occupy BASE..BASE+N-1. Legal only if 1 <= BASE and BASE+N <= 32.
- BF_LAT, 2, butterfly pipeline depth in cycles, counted from operands valid to results valid.

Ports:
- clk  in  1  clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled in IDLE only.
- abort  in  1  synchronous cancel.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at completion.
- stage  out  LOG2N bits (clog2 width)  current stage index.
- Raddr1  out  5  read address, A operand.
- Raddr2  out  5  read address, B operand.
- tw_idx  out  LOG2N-1  twiddle index, valid together with Raddr1/Raddr2.
- bf_valid  out  1  operands present on Rdata1/Rdata2 this cycle; one cycle after issue, because the RAM read is synchronous.
- w  out  1  write enable, port 1 (A result).
- w2  out  1  write enable, port 2 (B result).
- Waddr1  out  5  write address, port 1.
- Waddr2  out  5  write address, port 2.

Behaviour:
- Reset (asynchronous, nReset=0):
  - State is IDLE; all counters and delay-line valids are 0.
  - Outputs: busy=0, done=0, stage=0, Raddr1=Raddr2=0, tw_idx=0, bf_valid=0, w=w2=0, Waddr1=Waddr2=0.
  - w and w2 fall immediately, with no clock needed, including when reset arrives mid-transform.
- States IDLE -> RUN -> DRAIN -> (RUN | FINISH) -> IDLE.
  - IDLE: start=1 moves to RUN, with stage=0 and k=0.
  - RUN: one issue per cycle with k = 0..N/2-1. After k=N/2-1 is issued, move to DRAIN.
  - DRAIN: lasts exactly 1+BF_LAT cycles. It then moves to RUN for the next stage (k=0), or to FINISH if stage=LOG2N-1.
  - FINISH: one cycle with done=1, then IDLE.
- Issue address math for stage s, butterfly k:
  - span = 2**s
  - pos = k & (span-1)
  - grp = k >> s
  - Raddr1 = BASE + grp*2*span + pos
  - Raddr2 = Raddr1 + span
  - tw_idx = pos << (LOG2N-1-s)
- Read addresses hold their last value outside RUN; they are don't-care.
- Write path:
  - A shift register of depth 1+BF_LAT carries {valid, Raddr1, Raddr2}.
  - Writes for an issue in cycle t appear in cycle t+1+BF_LAT: w=w2=1, Waddr1/Waddr2 = the issued addresses.
  - Both write ports are always used together.
- Hazard rule: DRAIN guarantees the last write of a stage commits before the first read of the next stage. No read ever targets a write still in flight.
- Timing:
  - First issue occurs in the cycle after start is sampled.
  - Total time from first issue to done = LOG2N*(N/2+1+BF_LAT) cycles; 44 at the default parameters.
- start while busy or FINISH: ignored, no effect.
- abort=1 in any non-IDLE state:
  - Next state is IDLE.
  - All delay-line valids clear at the same edge, so no further w/w2 occur.
  - done is not pulsed.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, remain IDLE.
- No address generated is ever 0 or above 31; an assertion checks this.

Decomposition:
- Package fft_bf_pkg:
  - state enum {IDLE, RUN, DRAIN, FINISH}.
  - REG_AW=5.
  - Function pair_addr(stage, k, base) returning {a, b, tw}.
- Sub-module wr_delay: parameterised depth, data width 11 ({valid, two 5-bit addresses}), synchronous flush input (driven by abort), asynchronous clear on nReset.

Test Plan:
- Defaults. start pulse -> first issue Raddr1=16, Raddr2=17, tw_idx=0. bf_valid in the next cycle. w=w2=1 with Waddr1=16, Waddr2=17 exactly 3 cycles after issue.
- Stage 1, k=5 -> Raddr1=25, Raddr2=27, tw_idx=4. Stage 3, k=3 -> Raddr1=19, Raddr2=27, tw_idx=3.
- Full run:
  - done pulses exactly once, 44 cycles after the first issue.
  - 32 write cycles in total; no read of an address in the cycle range between its issue and its write.
  - busy=0 after done.
- abort during stage 2 DRAIN -> next cycle IDLE, busy=0, no further w/w2, done never asserted. A subsequent start restarts at stage 0, Raddr1=16.
- nReset low mid-RUN with writes in flight -> w=w2=0 immediately (asynchronous); after release all outputs hold reset values until start.
- start held high continuously -> back-to-back transforms. Each start is accepted only in IDLE, after FINISH; start pulses during busy are ignored (count of done pulses == accepted starts).

Source files
------------

// File: rtl/fft_bf_pkg.sv
// Shared types and address helper for the radix-2 DIT FFT butterfly scheduler.
//   state_t   : scheduler FSM states
//   pair_t    : {a, b, tw} for one butterfly issue
//   wr_ent_t  : write-delay-line entry {valid, a, b}
//   pair_addr : register addresses and twiddle index of butterfly k in a stage
package fft_bf_pkg;

   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   typedef struct packed {
      logic [REG_AW-1:0] a;
      logic [REG_AW-1:0] b;
      logic [REG_AW-1:0] tw;
   } pair_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] a;
      logic [REG_AW-1:0] b;
   } wr_ent_t;

   localparam int unsigned WR_W = $bits(wr_ent_t);

   // Butterfly k of stage s pairs samples (grp*2*span + pos) and (+span).
   function automatic pair_t pair_addr(input int unsigned log2n,
                                       input int unsigned stage,
                                       input int unsigned k,
                                       input int unsigned base);
      int unsigned span;
      int unsigned pos;
      int unsigned grp;
      int unsigned a;
      pair_t       r;
      span = 32'd1 << stage;
      pos  = k & (span - 32'd1);
      grp  = k >> stage;
      a    = base + grp * 32'd2 * span + pos;
      r.a  = REG_AW'(a);
      r.b  = REG_AW'(a + span);
      r.tw = REG_AW'(pos << (log2n - 32'd1 - stage));
      return r;
   endfunction

endpackage

// File: rtl/fft_bf_sched_if.sv
// Bus bundle between the FFT scheduler and its surroundings.
//   control : start, abort (in to scheduler); busy, done, stage (out)
//   read    : Raddr1, Raddr2, tw_idx, bf_valid (out)
//   write   : w, w2, Waddr1, Waddr2 (out)
// master = scheduler side, slave = control / register file / butterfly side.
interface fft_bf_sched_if #(
   parameter int unsigned LOG2N = 4
) ();
   import fft_bf_pkg::*;

   localparam int unsigned STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int unsigned TW_W  = LOG2N - 1;

   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic [STG_W-1:0]  stage;
   logic [REG_AW-1:0] Raddr1;
   logic [REG_AW-1:0] Raddr2;
   logic [TW_W-1:0]   tw_idx;
   logic              bf_valid;
   logic              w;
   logic              w2;
   logic [REG_AW-1:0] Waddr1;
   logic [REG_AW-1:0] Waddr2;

   modport master (
      input  start, abort,
      output busy, done, stage, Raddr1, Raddr2, tw_idx, bf_valid,
             w, w2, Waddr1, Waddr2
   );

   modport slave (
      output start, abort,
      input  busy, done, stage, Raddr1, Raddr2, tw_idx, bf_valid,
             w, w2, Waddr1, Waddr2
   );

endinterface

// File: rtl/wr_delay.sv
// Fixed-depth delay line for write-back entries.
//   clk, nReset : clock, async active-low clear of every stage
//   flush       : synchronous clear of the valid bit (MSB) in every stage
//   din / dout  : entry entering / leaving the line DEPTH cycles later
module wr_delay #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned W     = 11
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] pipe_q [DEPTH];
   logic [W-1:0] pipe_d [DEPTH];

   // Shift by one; a flush kills every in-flight valid, including the entry arriving now.
   always_comb begin
      pipe_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pipe_d[i][W-1] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bf_sched.sv
// In-place radix-2 DIT FFT butterfly scheduler over a 32-entry register file.
//   clk, nReset : clock, async active-low reset
//   bus.master  : start/abort in; busy/done/stage, read addresses + twiddle +
//                 bf_valid, and the paired write port controls out
// One butterfly is issued per RUN cycle; each stage is followed by a DRAIN of
// 1+BF_LAT cycles so the last write lands before the next stage reads.
// Samples live at BASE..BASE+N-1 (1 <= BASE, BASE+N <= 32).
module fft_bf_sched
   import fft_bf_pkg::*;
#(
   parameter int unsigned LOG2N  = 4,
   parameter int unsigned BASE   = 16,
   parameter int unsigned BF_LAT = 2
) (
   input  logic           clk,
   input  logic           nReset,
   fft_bf_sched_if.master bus
);

   localparam int unsigned HALF    = 32'd1 << (LOG2N - 1);
   localparam int unsigned STG_W   = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int unsigned TW_W    = LOG2N - 1;
   localparam int unsigned CNT_MAX = (HALF - 1 > BF_LAT) ? HALF - 1 : BF_LAT;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   state_t            state_q,    state_d;
   logic [STG_W-1:0]  stage_q,    stage_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [REG_AW-1:0] raddr1_q,   raddr1_d;
   logic [REG_AW-1:0] raddr2_q,   raddr2_d;
   logic [TW_W-1:0]   tw_q,       tw_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              bf_valid_q, bf_valid_d;

   pair_t             pa;
   wr_ent_t           wr_in;
   wr_ent_t           wr_out;
   logic              flush_c;

   // Next state, counters and the registered outputs for the coming cycle.
   // cnt is the butterfly index in RUN and the drain cycle count in DRAIN.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      cnt_d      = cnt_q;
      raddr1_d   = raddr1_q;
      raddr2_d   = raddr2_q;
      tw_d       = tw_q;
      pa         = '0;
      flush_c    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               stage_d = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(BF_LAT)) begin
               cnt_d = '0;
               if (stage_q == STG_W'(LOG2N - 1)) begin
                  state_d = FINISH;
               end else begin
                  state_d = RUN;
                  stage_d = stage_q + STG_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort beats everything outside IDLE, including a concurrent start.
      if (bus.abort) begin
         state_d = IDLE;
         flush_c = (state_q != IDLE);
      end

      if (state_d == IDLE) begin
         stage_d = '0;
         cnt_d   = '0;
      end

      // Read addresses are precomputed so they appear registered in the issue cycle.
      if (state_d == RUN) begin
         pa       = pair_addr(LOG2N, 32'(stage_d), 32'(cnt_d), BASE);
         raddr1_d = pa.a;
         raddr2_d = pa.b;
         tw_d     = TW_W'(pa.tw);
      end

      busy_d     = (state_d == RUN) || (state_d == DRAIN);
      done_d     = (state_d == FINISH);
      bf_valid_d = (state_q == RUN) && !bus.abort;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= IDLE;
         stage_q    <= '0;
         cnt_q      <= '0;
         raddr1_q   <= '0;
         raddr2_q   <= '0;
         tw_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bf_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         cnt_q      <= cnt_d;
         raddr1_q   <= raddr1_d;
         raddr2_q   <= raddr2_d;
         tw_q       <= tw_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bf_valid_q <= bf_valid_d;
      end
   end

   // The issued pair re-emerges as a write exactly 1+BF_LAT cycles later.
   always_comb begin
      wr_in.valid = (state_q == RUN);
      wr_in.a     = raddr1_q;
      wr_in.b     = raddr2_q;
   end

   wr_delay #(
      .DEPTH (1 + BF_LAT),
      .W     (WR_W)
   ) u_wr_delay (
      .clk    (clk),
      .nReset (nReset),
      .flush  (flush_c),
      .din    (wr_in),
      .dout   (wr_out)
   );

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.stage    = stage_q;
   assign bus.Raddr1   = raddr1_q;
   assign bus.Raddr2   = raddr2_q;
   assign bus.tw_idx   = tw_q;
   assign bus.bf_valid = bf_valid_q;
   assign bus.w        = wr_out.valid;
   assign bus.w2       = wr_out.valid;
   assign bus.Waddr1   = wr_out.a;
   assign bus.Waddr2   = wr_out.b;

   // %0 is hard-wired zero, and B above A rules out wrap past %31.
   a_raddr_legal: assert property (@(posedge clk) disable iff (!nReset)
      (state_q == RUN) |-> (raddr1_q != '0 && raddr2_q > raddr1_q));

   a_waddr_legal: assert property (@(posedge clk) disable iff (!nReset)
      wr_out.valid |-> (wr_out.a != '0 && wr_out.b > wr_out.a));

endmodule

// File: tb/tb_fft_bf_sched.sv
// Self-checking bench for fft_bf_sched: address table, full/aborted/random
// transforms against an arithmetic reference, async reset and held start.
module tb_fft_bf_sched;

   localparam int LOG2N  = 4;
   localparam int BASE   = 16;
   localparam int BF_LAT = 2;
   localparam int N      = 1 << LOG2N;
   localparam int HALF   = N / 2;
   localparam int SLEN   = HALF + 1 + BF_LAT;
   localparam int TOTAL  = LOG2N * SLEN;
   localparam int PERIOD = TOTAL + 2;

   logic clk = 1'b0;
   logic nReset;

   fft_bf_sched_if #(.LOG2N(LOG2N)) bus ();

   fft_bf_sched #(
      .LOG2N  (LOG2N),
      .BASE   (BASE),
      .BF_LAT (BF_LAT)
   ) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   bit   pend [32];
   int   obs_a  [LOG2N][HALF];
   int   obs_b  [LOG2N][HALF];
   int   obs_tw [LOG2N][HALF];
   vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int outs_vec();
      return int'({bus.busy, bus.done, bus.stage, bus.Raddr1, bus.Raddr2, bus.tw_idx,
                   bus.bf_valid, bus.w, bus.w2, bus.Waddr1, bus.Waddr2});
   endfunction

   // Reference pairing: butterfly k of stage s joins element j and j+span.
   task automatic ref_pair(input int s, input int k, output int a, output int b, output int tw);
      int span;
      span = 1 << s;
      a  = BASE + (k / span) * (2 * span) + (k % span);
      b  = a + span;
      tw = (k % span) * (HALF / span);
   endtask

   function automatic bit is_issue(input int o);
      return (o >= 0) && (o < TOTAL) && ((o % SLEN) < HALF);
   endfunction

   function automatic int exp_writes(input int oa);
      int c;
      c = 0;
      for (int o = 0; o < TOTAL; o++) begin
         if (is_issue(o) && (oa < 0 || o + 1 + BF_LAT <= oa)) c++;
      end
      return c;
   endfunction

   // Start a transform from IDLE and check every cycle; abort at offset oa (<0: none).
   task automatic run_transform(input int oa, input bit spurious,
                                output int n_done, output int n_wr);
      int lim, eff, a, b, tw, s, k;
      bit act, ew, ei;
      lim = (oa < 0) ? TOTAL + 2 : oa + 4;
      eff = (oa < 0) ? 1000000 : oa;
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      n_done = 0;
      n_wr   = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int o = 0; o <= lim; o++) begin
         act = (o <= eff) && (o <= TOTAL);
         chk($sformatf("busy@%0d", o), int'(bus.busy), int'(act && o < TOTAL));
         chk($sformatf("done@%0d", o), int'(bus.done), int'(act && o == TOTAL));
         chk($sformatf("bf_valid@%0d", o), int'(bus.bf_valid), int'(is_issue(o - 1) && (o - 1) < eff));
         ew = is_issue(o - 1 - BF_LAT) && (o <= eff);
         chk($sformatf("w@%0d", o), int'(bus.w), int'(ew));
         chk($sformatf("w2@%0d", o), int'(bus.w2), int'(ew));
         if (ew) begin
            ref_pair((o - 1 - BF_LAT) / SLEN, (o - 1 - BF_LAT) % SLEN, a, b, tw);
            chk($sformatf("Waddr1@%0d", o), int'(bus.Waddr1), a);
            chk($sformatf("Waddr2@%0d", o), int'(bus.Waddr2), b);
         end
         if (act && o < TOTAL) chk($sformatf("stage@%0d", o), int'(bus.stage), o / SLEN);
         ei = act && is_issue(o);
         if (ei) begin
            s = o / SLEN;
            k = o % SLEN;
            ref_pair(s, k, a, b, tw);
            chk($sformatf("Raddr1@%0d", o), int'(bus.Raddr1), a);
            chk($sformatf("Raddr2@%0d", o), int'(bus.Raddr2), b);
            chk($sformatf("tw_idx@%0d", o), int'(bus.tw_idx), tw);
            chk($sformatf("hazard_a@%0d", o), int'(pend[bus.Raddr1]), 0);
            chk($sformatf("hazard_b@%0d", o), int'(pend[bus.Raddr2]), 0);
            if (oa < 0) begin
               obs_a[s][k]  = int'(bus.Raddr1);
               obs_b[s][k]  = int'(bus.Raddr2);
               obs_tw[s][k] = int'(bus.tw_idx);
            end
         end
         if (bus.w) begin
            pend[bus.Waddr1] = 1'b0;
            pend[bus.Waddr2] = 1'b0;
            n_wr++;
         end
         if (ei) begin
            pend[bus.Raddr1] = 1'b1;
            pend[bus.Raddr2] = 1'b1;
         end
         if (bus.done) n_done++;
         bus.abort = (o == oa);
         bus.start = spurious && (o <= TOTAL) && (o < eff) && ($urandom_range(0, 3) == 0);
         tick();
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      int nd, nw, acc, exp_acc, gap, oa;
      bit prevb;

      bus.start = 1'b0;
      bus.abort = 1'b0;
      nReset    = 1'b0;
      tbl[0] = '{0, 0, 16, 17, 0};
      tbl[1] = '{1, 5, 25, 27, 4};
      tbl[2] = '{3, 3, 19, 27, 3};
      tbl[3] = '{0, 7, 30, 31, 0};
      tbl[4] = '{2, 6, 26, 30, 4};
      tbl[5] = '{3, 7, 23, 31, 7};
      tbl[6] = '{2, 0, 16, 20, 0};
      tbl[7] = '{1, 2, 20, 22, 0};
      for (int s = 0; s < LOG2N; s++) begin
         for (int k = 0; k < HALF; k++) begin
            obs_a[s][k]  = -1;
            obs_b[s][k]  = -1;
            obs_tw[s][k] = -1;
         end
      end

      // Reset values, during and after reset.
      #1;
      chk("reset_outs", outs_vec(), 0);
      repeat (3) @(posedge clk);
      #1;
      nReset = 1'b1;
      tick();
      chk("post_reset_outs", outs_vec(), 0);

      // Full transform.
      run_transform(-1, 1'b0, nd, nw);
      chk("full_done_count", nd, 1);
      chk("full_write_count", nw, 32);

      // Address table against the observed issues.
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tbl%0d_Raddr1", i), obs_a[tbl[i].s][tbl[i].k], tbl[i].a);
         chk($sformatf("tbl%0d_Raddr2", i), obs_b[tbl[i].s][tbl[i].k], tbl[i].b);
         chk($sformatf("tbl%0d_tw", i), obs_tw[tbl[i].s][tbl[i].k], tbl[i].tw);
      end

      // Abort in stage 2 DRAIN, then restart from stage 0.
      oa = 2 * SLEN + HALF + 1;
      run_transform(oa, 1'b0, nd, nw);
      chk("abort_done_count", nd, 0);
      chk("abort_write_count", nw, exp_writes(oa));
      run_transform(-1, 1'b0, nd, nw);
      chk("restart_done_count", nd, 1);

      // Abort together with start in IDLE: stays idle.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("abort_start_busy", int'(bus.busy), 0);
      tick();
      chk("abort_start_outs_busy", int'(bus.busy), 0);
      chk("abort_start_bfv", int'(bus.bf_valid), 0);

      // Asynchronous reset with writes in flight.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      chk("w_before_reset", int'(bus.w), 1);
      #2 nReset = 1'b0;
      #1;
      chk("w_async_reset", int'(bus.w), 0);
      chk("w2_async_reset", int'(bus.w2), 0);
      chk("outs_async_reset", outs_vec(), 0);
      tick();
      tick();
      nReset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("outs_after_release%0d", i), outs_vec(), 0);
      end

      // Start held high: back-to-back transforms, one accept per IDLE.
      bus.start = 1'b1;
      prevb = 1'b0;
      acc = 0;
      nd = 0;
      exp_acc = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         chk($sformatf("held_busy@%0d", c), int'(bus.busy), int'((c % PERIOD) < TOTAL));
         chk($sformatf("held_done@%0d", c), int'(bus.done), int'((c % PERIOD) == TOTAL));
         if (bus.busy && !prevb) acc++;
         prevb = bus.busy;
         if (bus.done) nd++;
         if ((c % PERIOD) == 0) exp_acc++;
      end
      bus.start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus.busy && !prevb) acc++;
         prevb = bus.busy;
         if (bus.done) nd++;
      end
      chk("held_accepted", acc, exp_acc);
      chk("held_done_vs_accepted", nd, acc);

      // Randomised transforms with idle aborts, spurious starts and random aborts.
      for (int it = 0; it < 10; it++) begin
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            bus.abort = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("rnd%0d_idle_busy%0d", it, g), int'(bus.busy), 0);
         end
         bus.abort = 1'b0;
         if ($urandom_range(0, 2) == 0) oa = -1;
         else oa = int'($urandom_range(0, TOTAL - 1));
         run_transform(oa, 1'b1, nd, nw);
         chk($sformatf("rnd%0d_done_count", it), nd, (oa < 0) ? 1 : 0);
         chk($sformatf("rnd%0d_write_count", it), nw, exp_writes(oa));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
